// File: rtl/upd7801_intc.sv
// Prioritised interrupt controller for the uPD780x core family.
// Synchronises N maskable lines plus NMI and hands one winner at a time to the CPU.
module upd7801_intc #(
    parameter int          NUM_IRQ     = 4,
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] VEC_BASE    = 16'h0040,
    parameter int          VEC_STRIDE  = 8
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               CE,
    input  logic [NUM_IRQ-1:0] IRQ_I,
    input  logic               NMI_I,
    input  logic [NUM_IRQ-1:0] EDGE_MODE,
    input  logic               IE,
    input  logic               MASK_WE,
    input  logic [NUM_IRQ-1:0] MASK_D,
    input  logic               CLR_WE,
    input  logic [NUM_IRQ-1:0] CLR_D,
    input  logic               INT_ACK,
    output logic               INT_REQ,
    output logic [3:0]         INT_ID,
    output logic [15:0]        INT_VEC,
    output logic [NUM_IRQ-1:0] MASK_Q,
    output logic [NUM_IRQ-1:0] PEND_Q
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_GUARD
    } state_t;

    // Bit NUM_IRQ of the sync/history vectors carries the NMI line.
    logic [NUM_IRQ:0]   sync_q [SYNC_STAGES];
    logic [NUM_IRQ:0]   hist_q;
    logic [NUM_IRQ:0]   sync_w;
    logic [NUM_IRQ:0]   rise_w;

    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic               nmi_q, nmi_d;

    state_t             state_q;
    logic               req_q;
    logic [3:0]         id_q;
    logic [15:0]        vec_q;

    logic               ack_w;
    logic [NUM_IRQ-1:0] ack_clr_w;
    logic               ack_nmi_w;
    logic [NUM_IRQ-1:0] cand_w;
    logic               any_w;
    logic [3:0]         win_id_w;
    logic [15:0]        win_vec_w;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= {NMI_I, IRQ_I};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_w = sync_q[SYNC_STAGES-1];
    assign rise_w = sync_w & ~hist_q;

    // Only a handshake accepted in REQ services the displayed winner.
    assign ack_w     = INT_ACK && (state_q == ST_REQ);
    assign ack_nmi_w = ack_w && (id_q == 4'd0);

    always_comb begin
        ack_clr_w = '0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            ack_clr_w[k] = ack_w && (id_q == 4'(k + 1));
        end
    end

    always_comb begin
        pend_d = '0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            if (EDGE_MODE[k]) begin
                pend_d[k] = rise_w[k]
                          | (pend_q[k]
                             & ~(CLR_WE & CLR_D[k])
                             & ~ack_clr_w[k]);
            end else begin
                pend_d[k] = sync_w[k];
            end
        end
    end

    assign nmi_d  = rise_w[NUM_IRQ] | (nmi_q & ~ack_nmi_w);
    assign mask_d = MASK_WE ? MASK_D : mask_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            hist_q <= '0;
            pend_q <= '0;
            mask_q <= '1;
            nmi_q  <= 1'b0;
        end else if (CE) begin
            hist_q <= sync_w;
            pend_q <= pend_d;
            mask_q <= mask_d;
            nmi_q  <= nmi_d;
        end
    end

    assign cand_w = pend_q & ~mask_q & {NUM_IRQ{IE}};
    assign any_w  = nmi_q | (|cand_w);

    // Scan high to low so the lowest index wins; NMI overrides all.
    always_comb begin
        win_id_w = 4'd0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (cand_w[k]) begin
                win_id_w = 4'(k + 1);
            end
        end
        if (nmi_q) begin
            win_id_w = 4'd0;
        end
    end

    assign win_vec_w = VEC_BASE + 16'(win_id_w) * 16'(VEC_STRIDE);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            id_q    <= 4'd0;
            vec_q   <= 16'h0000;
        end else if (CE) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (any_w) begin
                        state_q <= ST_REQ;
                        req_q   <= 1'b1;
                        id_q    <= win_id_w;
                        vec_q   <= win_vec_w;
                    end
                end
                ST_REQ: begin
                    if (INT_ACK) begin
                        state_q <= ST_GUARD;
                        req_q   <= 1'b0;
                    end else if (!any_w) begin
                        state_q <= ST_IDLE;
                        req_q   <= 1'b0;
                    end else begin
                        id_q  <= win_id_w;
                        vec_q <= win_vec_w;
                    end
                end
                ST_GUARD: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign INT_REQ = req_q;
    assign INT_ID  = id_q;
    assign INT_VEC = vec_q;
    assign MASK_Q  = mask_q;
    assign PEND_Q  = pend_q;

endmodule

// File: tb/tb_upd7801_intc.sv
// Directed bench for upd7801_intc: priority, handshake, NMI, level mode,
// clear/set race, reset and vector wrap-around.
module tb_upd7801_intc;

    logic        clk = 1'b0;
    logic        RESET, CE, NMI_I, IE, MASK_WE, CLR_WE, INT_ACK;
    logic [3:0]  IRQ_I, EDGE_MODE, MASK_D, CLR_D;
    logic        INT_REQ, w_req;
    logic [3:0]  INT_ID, w_id;
    logic [15:0] INT_VEC, w_vec;
    logic [3:0]  MASK_Q, PEND_Q, w_mask, w_pend;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    upd7801_intc u_dut (
        .CLK(clk), .RESET(RESET), .CE(CE), .IRQ_I(IRQ_I), .NMI_I(NMI_I),
        .EDGE_MODE(EDGE_MODE), .IE(IE), .MASK_WE(MASK_WE), .MASK_D(MASK_D),
        .CLR_WE(CLR_WE), .CLR_D(CLR_D), .INT_ACK(INT_ACK),
        .INT_REQ(INT_REQ), .INT_ID(INT_ID), .INT_VEC(INT_VEC),
        .MASK_Q(MASK_Q), .PEND_Q(PEND_Q)
    );

    upd7801_intc #(.VEC_BASE(16'hFFF8), .VEC_STRIDE(8)) u_wrap (
        .CLK(clk), .RESET(RESET), .CE(CE), .IRQ_I(IRQ_I), .NMI_I(NMI_I),
        .EDGE_MODE(EDGE_MODE), .IE(IE), .MASK_WE(MASK_WE), .MASK_D(MASK_D),
        .CLR_WE(CLR_WE), .CLR_D(CLR_D), .INT_ACK(INT_ACK),
        .INT_REQ(w_req), .INT_ID(w_id), .INT_VEC(w_vec),
        .MASK_Q(w_mask), .PEND_Q(w_pend)
    );

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, ".req"}, 16'(INT_REQ), 16'd0);
        chk({tag, ".id"}, 16'(INT_ID), 16'd0);
        chk({tag, ".vec"}, INT_VEC, 16'h0000);
        chk({tag, ".mask"}, 16'(MASK_Q), 16'h000F);
        chk({tag, ".pend"}, 16'(PEND_Q), 16'h0000);
    endtask

    initial begin
        RESET = 1'b1; CE = 1'b1; NMI_I = 1'b0; IE = 1'b0;
        MASK_WE = 1'b0; CLR_WE = 1'b0; INT_ACK = 1'b0;
        IRQ_I = 4'b0; EDGE_MODE = 4'hF; MASK_D = 4'b0; CLR_D = 4'b0;
        tick(3);
        RESET = 1'b0;
        chk_rst("reset");

        // Channel 2, edge mode, only channel 2 unmasked
        IE = 1'b1; MASK_WE = 1'b1; MASK_D = 4'b1011;
        tick();
        MASK_WE = 1'b0;
        chk("mask_load", 16'(MASK_Q), 16'h000B);
        IRQ_I[2] = 1'b1;
        tick(3);
        chk("t1.pend", 16'(PEND_Q), 16'h0004);
        chk("t1.req_early", 16'(INT_REQ), 16'd0);
        tick();
        chk("t1.req", 16'(INT_REQ), 16'd1);
        chk("t1.id", 16'(INT_ID), 16'd3);
        chk("t1.vec", INT_VEC, 16'h0058);

        // Service channel 2, then priority switch 4 -> 2
        INT_ACK = 1'b1;
        tick();
        INT_ACK = 1'b0;
        chk("t2.ack_req", 16'(INT_REQ), 16'd0);
        chk("t2.ack_pend", 16'(PEND_Q), 16'h0000);
        IRQ_I = 4'b0; MASK_WE = 1'b1; MASK_D = 4'b0000;
        tick();
        MASK_WE = 1'b0;
        IRQ_I[3] = 1'b1;
        tick(4);
        chk("t2.id4", 16'(INT_ID), 16'd4);
        chk("t2.vec4", INT_VEC, 16'h0060);
        IRQ_I[1] = 1'b1;
        tick(3);
        chk("t2.pend2", 16'(PEND_Q), 16'h000A);
        chk("t2.id_hold", 16'(INT_ID), 16'd4);
        tick();
        chk("t2.id2", 16'(INT_ID), 16'd2);
        chk("t2.vec2", INT_VEC, 16'h0050);
        chk("t2.req2", 16'(INT_REQ), 16'd1);
        INT_ACK = 1'b1;
        tick();
        INT_ACK = 1'b0;
        chk("t2.ack2_pend", 16'(PEND_Q), 16'h0008);
        chk("t2.ack2_req", 16'(INT_REQ), 16'd0);
        tick();
        chk("t2.guard_idle", 16'(INT_REQ), 16'd0);
        tick();
        chk("t2.rereq", 16'(INT_REQ), 16'd1);
        chk("t2.reid", 16'(INT_ID), 16'd4);
        INT_ACK = 1'b1;
        tick();
        INT_ACK = 1'b0; IRQ_I = 4'b0;
        tick(2);
        chk("t2.drain_pend", 16'(PEND_Q), 16'h0000);

        // NMI with IE=0 and everything masked
        IE = 1'b0; MASK_WE = 1'b1; MASK_D = 4'hF;
        tick();
        MASK_WE = 1'b0;
        NMI_I = 1'b1;
        tick(4);
        chk("t3.req", 16'(INT_REQ), 16'd1);
        chk("t3.id", 16'(INT_ID), 16'd0);
        chk("t3.vec", INT_VEC, 16'h0040);
        NMI_I = 1'b0;
        tick(3);
        NMI_I = 1'b1;
        tick(2);
        INT_ACK = 1'b1;
        tick();
        INT_ACK = 1'b0;
        chk("t3.ack_req", 16'(INT_REQ), 16'd0);
        tick();
        chk("t3.guard", 16'(INT_REQ), 16'd0);
        tick();
        chk("t3.rereq", 16'(INT_REQ), 16'd1);
        chk("t3.reid", 16'(INT_ID), 16'd0);
        INT_ACK = 1'b1;
        tick();
        INT_ACK = 1'b0; NMI_I = 1'b0;
        tick(3);
        chk("t3.cleared", 16'(INT_REQ), 16'd0);

        // Level channel 0 drops before ACK
        IE = 1'b1; EDGE_MODE = 4'b1110; MASK_WE = 1'b1; MASK_D = 4'b0000;
        tick();
        MASK_WE = 1'b0;
        IRQ_I[0] = 1'b1;
        tick(4);
        chk("t4.req", 16'(INT_REQ), 16'd1);
        chk("t4.id", 16'(INT_ID), 16'd1);
        IRQ_I[0] = 1'b0;
        tick(3);
        chk("t4.pend", 16'(PEND_Q), 16'h0000);
        tick();
        chk("t4.drop", 16'(INT_REQ), 16'd0);
        tick();
        chk("t4.stay_idle", 16'(INT_REQ), 16'd0);

        // Edge set beats simultaneous CLR, then reset mid-request
        EDGE_MODE = 4'hF;
        IRQ_I[2] = 1'b1;
        tick(2);
        CLR_WE = 1'b1; CLR_D = 4'b0100;
        tick();
        CLR_WE = 1'b0; CLR_D = 4'b0;
        chk("t5.set_wins", 16'(PEND_Q), 16'h0004);
        tick();
        chk("t5.req", 16'(INT_REQ), 16'd1);
        chk("t5.id", 16'(INT_ID), 16'd3);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk_rst("t5.reset");
        tick(3);
        chk("t5.fresh_edge", 16'(PEND_Q), 16'h0004);
        chk("t5.masked", 16'(INT_REQ), 16'd0);

        // Channel 0 vector wraps with base 16'hFFF8
        IRQ_I = 4'b0001; MASK_WE = 1'b1; MASK_D = 4'b1110;
        tick();
        MASK_WE = 1'b0;
        tick(3);
        chk("t6.req", 16'(INT_REQ), 16'd1);
        chk("t6.vec", INT_VEC, 16'h0048);
        chk("t6.wrap_id", 16'(w_id), 16'd1);
        chk("t6.wrap_vec", w_vec, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
